// File: rtl/program_loader_pkg.sv
// Shared types and widths for the program loader slice.
package program_loader_pkg;

  localparam int unsigned BCNT_W = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CHK,
    S_RUN,
    S_ERR
  } state_e;

endpackage

// File: rtl/loader_word_assembler.sv
// 8->32 big-endian shift register with byte counter; serves both the length field and payload words.
module loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              emit_i,
  output logic              last_o,
  output logic [WORD_W-1:0] word_next_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [WORD_W-BYTE_W-1:0] shift_q;
  logic [BCNT_W-1:0]        cnt_q;
  logic [WORD_W-1:0]        word_q;
  logic                     word_valid_q;

  // word_next_o is the complete word in the cycle its 4th byte is accepted
  assign last_o       = byte_valid_i && (cnt_q == '1);
  assign word_next_o  = {shift_q, byte_i};
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= last_o && emit_i;
      if (byte_valid_i) begin
        shift_q <= word_next_o[WORD_W-BYTE_W-1:0];
        cnt_q   <= cnt_q + 1'b1;
        if (last_o && emit_i) begin
          word_q <= word_next_o;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory, then releases the CPU.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);
  localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

  state_e      state_q;
  logic        rx_ready_q;
  logic        cpu_run_q;
  logic        load_error_q;
  logic [15:0] words_loaded_q;
  logic [15:0] len_q;
  logic [31:0] imem_addr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        accept;
  logic        emit;
  logic        last;
  logic [31:0] word_next;
  logic [31:0] word;
  logic        word_valid;

  assign accept = rx_valid && rx_ready_q;
  assign emit   = (state_q == S_LOAD);

  loader_word_assembler u_asm (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_valid_i (accept),
    .byte_i       (rx_data),
    .emit_i       (emit),
    .last_o       (last),
    .word_next_o  (word_next),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  assign rx_ready     = rx_ready_q;
  assign imem_we      = word_valid;
  assign imem_wdata   = word;
  assign imem_addr    = imem_addr_q;
  assign cpu_run      = cpu_run_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_loaded_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rx_ready_q     <= 1'b0;
      cpu_run_q      <= 1'b0;
      load_error_q   <= 1'b0;
      words_loaded_q <= '0;
      len_q          <= '0;
      imem_addr_q    <= BASE_ADDR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_LEN;
          rx_ready_q <= 1'b1;
        end
        S_LEN: begin
          if (last) begin
            if (word_next == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_q    <= S_CHK;
`else
              state_q    <= S_RUN;
              rx_ready_q <= 1'b0;
              cpu_run_q  <= 1'b1;
`endif
            end else if (word_next > MAX_W32) begin
              state_q      <= S_ERR;
              rx_ready_q   <= 1'b0;
              load_error_q <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              len_q   <= word_next[15:0];
            end
          end
        end
        S_LOAD: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (accept) begin
            csum_q <= csum_q ^ rx_data;
          end
`endif
          // Address and count advance with the strobe; the last word closes rx_ready so no byte slips in
          if (last) begin
            imem_addr_q <= BASE_ADDR + 32'({words_loaded_q, 2'b00});
            if (words_loaded_q != MAX_W16) begin
              words_loaded_q <= words_loaded_q + 16'd1;
            end
            if (words_loaded_q + 16'd1 == len_q) begin
              rx_ready_q <= 1'b0;
            end
          end
          if (word_valid && (words_loaded_q == len_q)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_q    <= S_CHK;
            rx_ready_q <= 1'b1;
`else
            state_q    <= S_RUN;
            cpu_run_q  <= 1'b1;
`endif
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            if (rx_data == csum_q) begin
              state_q   <= S_RUN;
              cpu_run_q <= 1'b1;
            end else begin
              state_q      <= S_ERR;
              load_error_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader (honours PROGRAM_LOADER_CHECKSUM_EN).
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        load_error;
  logic [15:0] words_loaded;

  program_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int stalls;

  // write monitor
  int          cyc = 0;
  logic [31:0] wa [$];
  logic [31:0] wd [$];
  logic [15:0] wl [$];
  int          we_cyc;
  int          run_cyc;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wl.push_back(words_loaded);
      we_cyc = cyc;
    end
    if (cpu_run === 1'b1 && run_cyc < 0) run_cyc = cyc;
  end

  typedef struct {
    logic [7:0]  b [16];
    int          nb;
    bit          thr;
    int          nw;
    logic [31:0] w [3];
    bit          run;
    bit          err;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    wl.delete();
    we_cyc  = -1;
    run_cyc = -1;
  endtask

  task automatic do_rst(input int n);
    rst      = 1'b1;
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'b0, imem_we}, 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'h0);
    chk({tag, "_cpu_run"}, {31'b0, cpu_run}, 32'd0);
    chk({tag, "_load_error"}, {31'b0, load_error}, 32'd0);
    chk({tag, "_words_loaded"}, {16'b0, words_loaded}, 32'd0);
  endtask

  task automatic wait_ready();
    bit r = 1'b0;
    int n = 0;
    while (!r && n < 10) begin
      @(negedge clk);
      r = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) begin
      total++;
      bad++;
      $display("FAIL wait_ready: got rx_ready=0 want 1 within 10 cycles");
    end
  endtask

  // entered and left at 1 time unit after a rising edge
  task automatic send(input logic [7:0] b, input bit thr);
    bit acc = 1'b0;
    int n = 0;
    if (thr) begin
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        stalls++;
        n++;
      end
    end
    rx_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h got not-accepted want accepted", b);
    end
  endtask

  // hold rx_valid high in the terminal state: nothing may be consumed or written
  task automatic hold_and_settle();
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    repeat (6) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v, input bit do_reset);
    logic [7:0] cs = 8'h00;
    string tag;
    tag = $sformatf("v%0d", idx);
    if (do_reset) do_rst(2);
    clear_mon();
    wait_ready();
    stalls = 0;
    for (int i = 0; i < v.nb; i++) begin
      send(v.b[i], v.thr);
      if (i >= 4) cs ^= v.b[i];
    end
    if (CS && v.run) send(cs, v.thr);
    hold_and_settle();
    chk({tag, "_nwrites"}, wa.size(), v.nw);
    for (int i = 0; i < v.nw; i++) begin
      if (i < wa.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), wa[i], 32'(4 * i));
        chk($sformatf("%s_data%0d", tag, i), wd[i], v.w[i]);
        chk($sformatf("%s_wl_at_we%0d", tag, i), {16'b0, wl[i]}, 32'(i + 1));
      end
    end
    chk({tag, "_cpu_run"}, {31'b0, cpu_run}, {31'b0, v.run});
    chk({tag, "_load_error"}, {31'b0, load_error}, {31'b0, v.err});
    chk({tag, "_words_loaded"}, {16'b0, words_loaded}, 32'(v.nw));
    chk({tag, "_rx_ready_end"}, {31'b0, rx_ready}, 32'd0);
    if (!v.thr) chk({tag, "_stalls"}, stalls, (CS && v.nw > 0) ? 32'd1 : 32'd0);
    if (!CS && v.run && v.nw > 0) chk({tag, "_run_latency"}, run_cyc - we_cyc, 32'd1);
  endtask

  function automatic logic [31:0] dw(input int i);
    logic [7:0] x;
    x = 8'(i);
    return {x, 8'hC3, ~x, 8'h5A};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    vt[0].b = '{8'h00,8'h00,8'h00,8'h02, 8'h20,8'h08,8'h00,8'h05, 8'h01,8'h09,8'h50,8'h20, 8'h0,8'h0,8'h0,8'h0};
    vt[0].nb = 12; vt[0].thr = 0; vt[0].nw = 2; vt[0].run = 1; vt[0].err = 0;
    vt[0].w = '{32'h2008_0005, 32'h0109_5020, 32'h0};

    vt[1].b = '{8'h00,8'h00,8'h00,8'h00, 8'h0,8'h0,8'h0,8'h0, 8'h0,8'h0,8'h0,8'h0, 8'h0,8'h0,8'h0,8'h0};
    vt[1].nb = 4; vt[1].thr = 0; vt[1].nw = 0; vt[1].run = 1; vt[1].err = 0;
    vt[1].w = '{32'h0, 32'h0, 32'h0};

    vt[2].b = '{8'h00,8'h00,8'h01,8'h01, 8'h0,8'h0,8'h0,8'h0, 8'h0,8'h0,8'h0,8'h0, 8'h0,8'h0,8'h0,8'h0};
    vt[2].nb = 4; vt[2].thr = 0; vt[2].nw = 0; vt[2].run = 0; vt[2].err = 1;
    vt[2].w = '{32'h0, 32'h0, 32'h0};

    vt[3].b = '{8'h00,8'h00,8'h00,8'h03, 8'h8C,8'h01,8'h00,8'h04, 8'hAC,8'h02,8'h00,8'h08, 8'h00,8'h22,8'h18,8'h20};
    vt[3].nb = 16; vt[3].thr = 1; vt[3].nw = 3; vt[3].run = 1; vt[3].err = 0;
    vt[3].w = '{32'h8C01_0004, 32'hAC02_0008, 32'h0022_1820};

    vt[4] = vt[3];
    vt[4].thr = 0;

    vt[5].b = '{8'h01,8'h00,8'h00,8'h00, 8'h0,8'h0,8'h0,8'h0, 8'h0,8'h0,8'h0,8'h0, 8'h0,8'h0,8'h0,8'h0};
    vt[5].nb = 4; vt[5].thr = 0; vt[5].nw = 0; vt[5].run = 0; vt[5].err = 1;
    vt[5].w = '{32'h0, 32'h0, 32'h0};

    // reset values and the single IDLE cycle
    do_rst(3);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_then_len_rx_ready", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) run_vec(k, vt[k], 1'b1);

    // reset after 6 payload bytes, then a fresh frame
    do_rst(2);
    clear_mon();
    wait_ready();
    stalls = 0;
    for (int i = 0; i < 10; i++) send(vt[0].b[i], 1'b0);
    @(negedge clk);
    chk("midrst_pre_writes", wa.size(), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    run_vec(10, vt[0], 1'b0);

    // largest legal program: N == MAX_WORDS
    begin
      logic [7:0]  cs = 8'h00;
      logic [31:0] w;
      int          errs = 0;
      do_rst(2);
      clear_mon();
      wait_ready();
      send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0);
      for (int i = 0; i < 256; i++) begin
        w = dw(i);
        for (int j = 3; j >= 0; j--) begin
          send(w[8*j +: 8], 1'b0);
          cs ^= w[8*j +: 8];
        end
      end
      if (CS) send(cs, 1'b0);
      hold_and_settle();
      chk("max_nwrites", wa.size(), 32'd256);
      for (int i = 0; i < 256 && i < wa.size(); i++) begin
        if (wa[i] !== 32'(4 * i) || wd[i] !== dw(i)) errs++;
      end
      chk("max_data_errs", errs, 32'd0);
      if (wa.size() == 256) chk("max_last_addr", wa[255], 32'h0000_03FC);
      chk("max_words_loaded", {16'b0, words_loaded}, 32'd256);
      chk("max_cpu_run", {31'b0, cpu_run}, 32'd1);
      chk("max_load_error", {31'b0, load_error}, 32'd0);
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    for (int t = 0; t < 2; t++) begin
      do_rst(2);
      clear_mon();
      wait_ready();
      send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
      send(8'hAA, 1'b0); send(8'h55, 1'b0); send(8'h00, 1'b0); send(8'hFF, 1'b0);
      send((t == 0) ? 8'h00 : 8'h01, 1'b0);
      hold_and_settle();
      chk($sformatf("cs%0d_nwrites", t), wa.size(), 32'd1);
      if (wd.size() > 0) chk($sformatf("cs%0d_data", t), wd[0], 32'hAA55_00FF);
      chk($sformatf("cs%0d_cpu_run", t), {31'b0, cpu_run}, (t == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cs%0d_load_error", t), {31'b0, load_error}, (t == 0) ? 32'd0 : 32'd1);
      chk($sformatf("cs%0d_rx_ready", t), {31'b0, rx_ready}, 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
